// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// fetch_stage_pkg : shared widths, FSM encodings, reset constants, IF/ID word
// Rev 1.0
// ============================================================================
package fetch_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_word_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// fetch_stage_if : instruction-memory request/ack bus (master = fetch stage)
// Rev 1.0
// ============================================================================
interface fetch_stage_if;

  logic                              req;
  logic [fetch_stage_pkg::XLEN-1:0]  addr;
  logic                              ack;
  logic [fetch_stage_pkg::XLEN-1:0]  rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface
`default_nettype wire

// File: rtl/fetch_hold_buf.sv
`default_nettype none
// ============================================================================
// fetch_hold_buf : one-entry {valid,instr,pc} buffer for words returned under stall
// Rev 1.0
// ============================================================================
module fetch_hold_buf
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        consume,
  input  logic        clear,
  input  fetch_word_t load_word,
  output logic        valid,
  output fetch_word_t word
);

  // load wins over consume so a word can pass through while the old one drains
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      word  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      word  <= load_word;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : PC/FSM, imem request, IF/ID register; FETCH_STATS_EN adds counters
// Rev 1.0
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
)
(
  input  logic             clk,
  input  logic             rst,
  fetch_stage_if.master    imem,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             hlt_i,
  output logic [XLEN-1:0]  instr_o,
  output logic [XLEN-1:0]  pc_o,
  output logic             bubble_o,
`ifdef FETCH_STATS_EN
  output logic [31:0]      stat_fetched,
  output logic [31:0]      stat_bubbles,
`endif
  output logic             halted_o
);

  logic [1:0]      state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] drain_addr;
  logic [XLEN-1:0] ifid_instr;
  logic            outstanding;
  logic            halt_pend;

  logic            req;
  logic            ack_now;
  logic            take_halt;
  logic            active;
  logic            ifid_load;
  logic            hold_load;
  logic            hold_consume;
  logic            hold_clear;
  logic            hold_valid;
  fetch_word_t     hold_word;
  fetch_word_t     ack_word;
  fetch_word_t     ifid_word;

  // an issued request is never withdrawn; only reset can drop it
  assign req       = !rst && (outstanding ||
                              (state == ST_FETCH && !stall_i && !halt_pend));
  assign ack_now   = req && imem.ack;
  assign imem.req  = req;
  assign imem.addr = (state == ST_DRAIN) ? drain_addr : pc;

  assign take_halt = (state == ST_FETCH) && !halt_pend && hlt_i && !bubble_o && !redirect_i;
  assign active    = (state == ST_FETCH) && !redirect_i && !halt_pend && !take_halt;

  assign ack_word     = '{instr: imem.rdata, pc: pc};
  assign hold_load    = active && ack_now && (stall_i || hold_valid);
  assign hold_consume = active && !stall_i && hold_valid;
  assign hold_clear   = redirect_i || take_halt;
  assign ifid_load    = active && !stall_i && (hold_valid || ack_now);
  assign ifid_word    = hold_valid ? hold_word : ack_word;

  fetch_hold_buf u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (hold_load),
    .consume   (hold_consume),
    .clear     (hold_clear),
    .load_word (ack_word),
    .valid     (hold_valid),
    .word      (hold_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      drain_addr  <= '0;
      outstanding <= 1'b0;
      halt_pend   <= 1'b0;
      ifid_instr  <= NOP_INSTR;
      pc_o        <= '0;
      bubble_o    <= 1'b1;
    end else begin
      outstanding <= req && !imem.ack;
      case (state)
        ST_FETCH: begin
          if (redirect_i) begin
            pc        <= align_pc(redirect_pc);
            bubble_o  <= 1'b1;
            halt_pend <= 1'b0;
            if (req && !imem.ack) begin
              state      <= ST_DRAIN;
              drain_addr <= pc;
            end
          end else if (halt_pend) begin
            if (ack_now) state <= ST_HALT;
          end else if (take_halt) begin
            bubble_o <= 1'b1;
            if (req && !imem.ack) halt_pend <= 1'b1;
            else                  state     <= ST_HALT;
          end else begin
            if (ack_now) pc <= pc + 32'd4;
            if (ifid_load) begin
              ifid_instr <= ifid_word.instr;
              pc_o       <= ifid_word.pc;
              bubble_o   <= 1'b0;
            end else if (!stall_i) begin
              bubble_o <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          // pc already holds the redirect target; a newer redirect replaces it
          bubble_o <= 1'b1;
          if (redirect_i) pc <= align_pc(redirect_pc);
          if (imem.ack)   state <= ST_FETCH;
        end
        default: begin
          state    <= ST_HALT;
          bubble_o <= 1'b1;
        end
      endcase
    end
  end

  assign instr_o  = bubble_o ? NOP_INSTR : ifid_instr;
  assign halted_o = (state == ST_HALT);

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_fetched <= '0;
      stat_bubbles <= '0;
    end else begin
      if (ifid_load)                      stat_fetched <= stat_fetched + 32'd1;
      if (bubble_o && state != ST_HALT)   stat_bubbles <= stat_bubbles + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// tb_fetch_stage : vector table plus scoreboard of expected IF/ID words for fetch_stage.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  typedef struct {
    int          lat;
    logic [31:0] target;
    logic [31:0] exp_base;
    int          n;
    int          exp_bub;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        hlt_en = 1'b0;
  logic        hlt_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        bubble_o;
  logic        halted_o;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_bubbles;
`endif

  int   lat = 1;
  int   wait_cnt;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  vec_t vecs[4];

  fetch_stage_if imem();

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    if (a == 32'h40) return 32'hFFFF_FFFF;
    return {~a[15:0] ^ 16'h1357, a[15:0]};
  endfunction

  // memory: acks after lat cycles of request (lat=1 means same cycle)
  assign imem.ack   = imem.req && (wait_cnt >= lat - 1);
  assign imem.rdata = mem_word(imem.addr);
  assign hlt_i      = hlt_en && !bubble_o && (instr_o == 32'hFFFF_FFFF);

  always @(posedge clk or posedge rst) begin
    if (rst)                        wait_cnt <= 0;
    else if (imem.req && imem.ack)  wait_cnt <= 0;
    else if (imem.req)              wait_cnt <= wait_cnt + 1;
  end

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem),
    .stall_i     (stall_i),
    .redirect_i  (redirect_i),
    .redirect_pc (redirect_pc),
    .hlt_i       (hlt_i),
    .instr_o     (instr_o),
    .pc_o        (pc_o),
    .bubble_o    (bubble_o),
`ifdef FETCH_STATS_EN
    .stat_fetched(stat_fetched),
    .stat_bubbles(stat_bubbles),
`endif
    .halted_o    (halted_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_stream(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{pc: base + 32'(4 * i), instr: mem_word(base + 32'(4 * i))});
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_i  = 1'b1;
    redirect_pc = target;
    step();
    redirect_i  = 1'b0;
  endtask

  task automatic drain_sb(input int budget, output int bub, output logic [31:0] last_pc);
    exp_t        e;
    bit          started;
    bit          pend;
    logic [31:0] paddr;
    started = 1'b0; pend = 1'b0; paddr = '0; bub = 0; last_pc = '0;
    for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (pend) begin
        check("req_held", {31'd0, imem.req}, 32'd1);
        check("addr_stable", imem.addr, paddr);
      end
      if (!bubble_o) begin
        e = exp_q.pop_front();
        check("sb_pc", pc_o, e.pc);
        check("sb_instr", instr_o, e.instr);
        last_pc = pc_o;
        started = 1'b1;
      end else if (started) begin
        bub++;
      end
      pend  = imem.req && !imem.ack;
      paddr = imem.addr;
    end
    check("sb_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          bub;
    logic [31:0] last;
    logic [31:0] a0;

    vecs[0] = '{1, 32'h0000_0100, 32'h0000_0100, 6, 0};
    vecs[1] = '{3, 32'h0000_0200, 32'h0000_0200, 5, 8};
    vecs[2] = '{2, 32'h0000_0303, 32'h0000_0300, 4, 3};
    vecs[3] = '{4, 32'h0000_1000, 32'h0000_1000, 3, 6};

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_req",    {31'd0, imem.req}, 32'd0);
    check("rst_bubble", {31'd0, bubble_o}, 32'd1);
    check("rst_instr",  instr_o, 32'h0000_0013);
    check("rst_pc_o",   pc_o, 32'h0);
    check("rst_halted", {31'd0, halted_o}, 32'd0);

    // ack tied to req: back-to-back stream from RESET_PC
    push_stream(32'h0, 8);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("first_req",  {31'd0, imem.req}, 32'd1);
    check("first_addr", imem.addr, 32'h0);
    drain_sb(100, bub, last);
    check("tied_bubbles", bub, 32'd0);
    check("tied_last_pc", last, 32'h1C);

    // redirect targets at various latencies
    for (int i = 0; i < 4; i++) begin
      lat = vecs[i].lat;
      exp_q.delete();
      push_stream(vecs[i].exp_base, vecs[i].n);
      redirect_to(vecs[i].target);
      drain_sb(200, bub, last);
      check("vec_bubbles", bub, vecs[i].exp_bub);
      check("vec_last_pc", last, vecs[i].exp_base + 32'(4 * (vecs[i].n - 1)));
    end

    // redirect while 0x20 is outstanding: its data must be dropped
    lat = 3;
    exp_q.delete();
    redirect_to(32'h20);
    for (int c = 0; c < 20; c++) begin
      if (imem.req && imem.addr == 32'h20 && wait_cnt == 0) break;
      step();
    end
    check("drop_setup_addr", imem.addr, 32'h20);
    push_stream(32'h100, 3);
    redirect_to(32'h100);
    check("drain_req",    {31'd0, imem.req}, 32'd1);
    check("drain_addr",   imem.addr, 32'h20);
    check("drain_bubble", {31'd0, bubble_o}, 32'd1);
    for (int c = 0; c < 10; c++) begin
      step();
      if (imem.req && imem.addr != 32'h20) break;
    end
    check("redirect_next_addr", imem.addr, 32'h100);
    drain_sb(100, bub, last);

    // stall while 0xDEADBEEF @0x10 returns
    exp_q.delete();
    redirect_to(32'h10);
    for (int c = 0; c < 20; c++) begin
      if (imem.req && imem.addr == 32'h10 && wait_cnt == 0) break;
      step();
    end
    check("stall_setup_addr", imem.addr, 32'h10);
    step();
    stall_i = 1'b1;
    step();
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall_bubble", {31'd0, bubble_o}, 32'd1);
      check("stall_instr",  instr_o, 32'h0000_0013);
      check("stall_no_req", {31'd0, imem.req}, 32'd0);
    end
    stall_i = 1'b0;
    #1;
    check("resume_req",  {31'd0, imem.req}, 32'd1);
    check("resume_addr", imem.addr, 32'h14);
    step();
    check("unstall_instr",  instr_o, 32'hDEAD_BEEF);
    check("unstall_pc",     pc_o, 32'h10);
    check("unstall_bubble", {31'd0, bubble_o}, 32'd0);

    // halt opcode with same-cycle redirect: redirect wins
    lat = 1;
    hlt_en = 1'b1;
    exp_q.delete();
    redirect_to(32'h38);
    for (int c = 0; c < 20; c++) begin
      if (!bubble_o && instr_o == 32'hFFFF_FFFF) break;
      step();
    end
    check("halt_word_seen", instr_o, 32'hFFFF_FFFF);
    push_stream(32'h80, 3);
    redirect_to(32'h80);
    check("redirect_beats_halt", {31'd0, halted_o}, 32'd0);
    drain_sb(50, bub, last);

    // halt opcode alone: terminal
    exp_q.delete();
    redirect_to(32'h40);
    for (int c = 0; c < 20; c++) begin
      if (halted_o) break;
      step();
    end
    check("halted", {31'd0, halted_o}, 32'd1);
    for (int c = 0; c < 6; c++) begin
      step();
      check("halt_no_req", {31'd0, imem.req}, 32'd0);
      check("halt_bubble", {31'd0, bubble_o}, 32'd1);
      check("halt_stays",  {31'd0, halted_o}, 32'd1);
    end

    // reset asserted mid-DRAIN
    hlt_en = 1'b0;
    rst = 1'b1;
    step();
    check("rst_clears_halt", {31'd0, halted_o}, 32'd0);
    rst = 1'b0;
    redirect_to(32'h500);
    step();
    step();
    lat = 4;
    a0 = imem.addr;
    check("pre_drain_addr", a0, 32'h508);
    step();
    redirect_to(32'h200);
    check("in_drain_req",  {31'd0, imem.req}, 32'd1);
    check("in_drain_addr", imem.addr, 32'h508);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_req",    {31'd0, imem.req}, 32'd0);
    check("mid_rst_bubble", {31'd0, bubble_o}, 32'd1);
    check("mid_rst_instr",  instr_o, 32'h0000_0013);
    check("mid_rst_pc_o",   pc_o, 32'h0);
    check("mid_rst_halted", {31'd0, halted_o}, 32'd0);
    step();
    step();
    exp_q.delete();
    push_stream(32'h0, 3);
    lat = 1;
    rst = 1'b0;
    #1;
    check("post_rst_req",  {31'd0, imem.req}, 32'd1);
    check("post_rst_addr", imem.addr, 32'h0);
    drain_sb(50, bub, last);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
